// File: rtl/cuadrado.sv
// Purpose: iterative shift-add squarer (base*base), iniciar/terminado start-done handshake.
// Latency: WIDTH+1 clocks from the accepting edge to terminado; next start accepted one edge later.
// Backpressure: iniciar is ignored while ocupado=1 (no queuing, no restart); result held until next FIN.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   iniciar, base    start request and unsigned operand (captured only on an accepted start)
//   cuadrado_res     2*WIDTH-bit square of the last completed operation
//   desborde         upper half of cuadrado_res is non-zero (does not fit the WIDTH-bit bus)
//   terminado        result valid, cleared by the next accepted start
//   ocupado          operation in progress
module cuadrado #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iniciar,
    input  logic [WIDTH-1:0]     base,
    output logic [2*WIDTH-1:0]   cuadrado_res,
    output logic                 desborde,
    output logic                 terminado,
    output logic                 ocupado
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   res_q;
    logic                 desborde_q;
    logic                 terminado_q;
    logic                 ocupado_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            desborde_q  <= 1'b0;
            terminado_q <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iniciar) begin
                        mcand_q     <= {{WIDTH{1'b0}}, base};
                        mplier_q    <= base;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        terminado_q <= 1'b0;
                        ocupado_q   <= 1'b1;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    // Always WIDTH steps, even once mplier is exhausted, so latency is fixed.
                    // A WIDTH x WIDTH product fits in 2*WIDTH bits, so the sum never carries out.
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    res_q       <= acc_q;
                    desborde_q  <= |acc_q[2*WIDTH-1:WIDTH];
                    terminado_q <= 1'b1;
                    ocupado_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cuadrado_res = res_q;
    assign desborde     = desborde_q;
    assign terminado    = terminado_q;
    assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_cuadrado.sv
// Purpose: self-checking bench for cuadrado; expected squares queued at each accept, compared on terminado rise.
// Latency: each queued entry carries its accept cycle; completion must arrive exactly 17 clocks later.
// Backpressure: covers ignored mid-operation start, async reset abort and held-high back-to-back starts.
module tb_cuadrado;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic            iniciar;
    logic [W-1:0]    base;
    logic [2*W-1:0]  cuadrado_res;
    logic            desborde;
    logic            terminado;
    logic            ocupado;

    cuadrado #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iniciar      (iniciar),
        .base         (base),
        .cuadrado_res (cuadrado_res),
        .desborde     (desborde),
        .terminado    (terminado),
        .ocupado      (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           dsb;
        int             acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_done = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic term_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [W-1:0] b, input int c);
        exp_t e;
        logic [2*W-1:0] sq;
        sq        = (2*W)'(b) * (2*W)'(b);
        e.res     = sq;
        e.dsb     = |sq[2*W-1:W];
        e.acc_cyc = c;
        return e;
    endfunction

    // Completion monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (terminado && !term_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", 64'(cuadrado_res), 64'(e.res));
                chk("desborde", 64'(desborde), 64'(e.dsb));
                chk("latency", 64'(cyc - e.acc_cyc), 64'd17);
                chk("ocupado_at_done", 64'(ocupado), 64'd0);
            end
            n_done++;
        end
        term_prev = terminado;
    end

    // Single-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic start(input logic [W-1:0] b);
        @(negedge clk);
        base    = b;
        iniciar = 1'b1;
        @(negedge clk);
        q.push_back(mk_exp(b, cyc));
        iniciar = 1'b0;
    endtask

    task automatic wait_done(input int start_n);
        for (int i = 0; i < 40 && n_done == start_n; i++) @(negedge clk);
        chk("done_seen", 64'(n_done - start_n), 64'd1);
    endtask

    initial begin
        int nd;
        rst_n   = 1'b0;
        iniciar = 1'b0;
        base    = '0;
        #13;
        chk("rst_res", 64'(cuadrado_res), 64'd0);
        chk("rst_flags", 64'({desborde, terminado, ocupado}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 0..255, with integer-sqrt round trip on the low half.
        for (int b = 0; b < 256; b++) begin
            nd = n_done;
            start(W'(b));
            wait_done(nd);
            chk("isqrt", 64'(isqrt(int'(cuadrado_res[W-1:0]))), 64'(b));
        end

        // Overflow boundaries.
        nd = n_done; start(16'd256);   wait_done(nd);
        nd = n_done; start(16'd65535); wait_done(nd);
        chk("max_res", 64'(cuadrado_res), 64'hFFFE0001);

        // Start while busy is ignored; ocupado stays high throughout.
        nd = n_done;
        start(16'd3);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                base    = 16'd9;
                iniciar = 1'b1;
            end else begin
                iniciar = 1'b0;
            end
            chk("busy_ocupado", 64'(ocupado), 64'd1);
            @(negedge clk);
        end
        iniciar = 1'b0;
        wait_done(nd);

        // Asynchronous reset mid-operation discards the in-flight result.
        start(16'd100);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res", 64'(cuadrado_res), 64'd0);
        chk("arst_flags", 64'({desborde, terminado, ocupado}), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = n_done;
        start(16'd12);
        wait_done(nd);
        chk("after_rst_res", 64'(cuadrado_res), 64'd144);

        // iniciar held high: restarts 18 clocks apart with base 1,2,3.
        @(negedge clk);
        base    = 16'd1;
        iniciar = 1'b1;
        @(negedge clk);
        q.push_back(mk_exp(16'd1, cyc));
        base = 16'd2;
        for (int k = 2; k <= 3; k++) begin
            nd = n_done;
            wait_done(nd);
            q.push_back(mk_exp(W'(k), cyc + 1));
            @(negedge clk);
            chk("b2b_term_drop", 64'(terminado), 64'd0);
            chk("b2b_ocupado", 64'(ocupado), 64'd1);
            chk("b2b_res_held", 64'(cuadrado_res), 64'((k - 1) * (k - 1)));
            base = W'(k + 1);
        end
        nd = n_done;
        wait_done(nd);
        iniciar = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_last_res", 64'(cuadrado_res), 64'd9);
        chk("no_restart", 64'(ocupado), 64'd0);
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
